// File: rtl/ins_miss_queue.sv
// rtl/ins_miss_queue.sv - instruction-cache miss-request queue with duplicate merge and req/ack issue
//
// Purpose: captures line addresses emitted by the instruction cache, merges
// duplicates already pending, and issues them one at a time to the next-level
// cache over a registered req/ack handshake. Keeps issued/merged/dropped counts.
//
// Ports:
//   clk_i        clock, all state changes on rising edge
//   reset_i      asynchronous active-high reset
//   flush_i      synchronous clear, highest priority after reset
//   req_valid_i  line address presented this cycle
//   req_addr_i   line address (address bits [31:6])
//   l2_req_o     registered request to next level
//   l2_addr_o    registered address of the current request
//   l2_ack_i     next level accepted l2_addr_o (only honoured while l2_req_o = 1)
//   full_o       count == DEPTH
//   empty_o      count == 0
//   count_o      occupied entries
//   issued_o     requests acknowledged
//   merged_o     requests absorbed as duplicates
//   dropped_o    requests lost to overflow
module ins_miss_queue #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 26
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       flush_i,
    input  logic                       req_valid_i,
    input  logic [ADDR_W-1:0]          req_addr_i,
    output logic                       l2_req_o,
    output logic [ADDR_W-1:0]          l2_addr_o,
    input  logic                       l2_ack_i,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic [31:0]                issued_o,
    output logic [31:0]                merged_o,
    output logic [31:0]                dropped_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic {
        IDLE,
        ISSUE
    } state_t;

    logic [ADDR_W-1:0] entry_q [DEPTH];
    logic [DEPTH-1:0]  valid_q, valid_d;
    logic [PW-1:0]     head_q, head_d;
    logic [PW-1:0]     tail_q, tail_d;
    logic [CW-1:0]     count_q, count_d;
    state_t            state_q;
    logic              l2_req_q;
    logic [ADDR_W-1:0] l2_addr_q;
    logic [31:0]       issued_q, merged_q, dropped_q;

    logic hit;
    logic pop;
    logic do_merge;
    logic do_push;
    logic do_drop;

    // Duplicate check covers every valid entry as it stands before the edge,
    // including the head that may be popped this same edge.
    always_comb begin
        hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && (entry_q[i] == req_addr_i)) begin
                hit = 1'b1;
            end
        end
    end

    assign pop      = (state_q == ISSUE) && l2_ack_i;
    assign do_merge = req_valid_i && hit;
    // A pop frees the head slot this edge, so a full queue can still accept.
    assign do_push  = req_valid_i && !hit && ((count_q != DEPTH_C) || pop);
    assign do_drop  = req_valid_i && !hit && !do_push;

    always_comb begin
        valid_d = valid_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        // Clear before set: when full with a pop, tail == head and the new
        // entry must own the vacated slot.
        if (pop) begin
            valid_d[head_q] = 1'b0;
            head_d          = head_q + PW'(1);
        end
        if (do_push) begin
            valid_d[tail_q] = 1'b1;
            tail_d          = tail_q + PW'(1);
        end
        case ({do_push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!flush_i && do_push) begin
            entry_q[tail_q] <= req_addr_i;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            valid_q   <= '0;
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            state_q   <= IDLE;
            l2_req_q  <= 1'b0;
            l2_addr_q <= '0;
            issued_q  <= '0;
            merged_q  <= '0;
            dropped_q <= '0;
        end else if (flush_i) begin
            valid_q   <= '0;
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            state_q   <= IDLE;
            l2_req_q  <= 1'b0;
            issued_q  <= '0;
            merged_q  <= '0;
            dropped_q <= '0;
        end else begin
            valid_q <= valid_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            if (do_merge) begin
                merged_q <= merged_q + 32'd1;
            end
            if (do_drop) begin
                dropped_q <= dropped_q + 32'd1;
            end
            case (state_q)
                IDLE: begin
                    if (count_q != '0) begin
                        l2_addr_q <= entry_q[head_q];
                        l2_req_q  <= 1'b1;
                        state_q   <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (l2_ack_i) begin
                        issued_q <= issued_q + 32'd1;
                        l2_req_q <= 1'b0;
                        state_q  <= IDLE;
                    end
                end
                default: begin
                    l2_req_q <= 1'b0;
                    state_q  <= IDLE;
                end
            endcase
        end
    end

    assign l2_req_o  = l2_req_q;
    assign l2_addr_o = l2_addr_q;
    assign count_o   = count_q;
    assign full_o    = (count_q == DEPTH_C);
    assign empty_o   = (count_q == '0);
    assign issued_o  = issued_q;
    assign merged_o  = merged_q;
    assign dropped_o = dropped_q;

endmodule

// File: doc/ins_miss_queue.md
# ins_miss_queue

Miss-request queue between the instruction cache and the next-level cache. Captures each 26-bit line address the instruction cache emits on a fill or eviction refill, merges duplicates already pending, and issues them one at a time to the next level over a req/ack handshake. Keeps 32-bit issued, merged and dropped counts for the statistics module.

## Interface
Parameters:
- DEPTH, 4: queue entries; power of two, at least 2.
- ADDR_W, 26: line-address width, equal to address bits [31:6].

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- flush  in  1  synchronous clear, driven while the trace command is RESET (n = 8).
- req_valid  in  1  the instruction cache emitted a line address this cycle (add_out not Z).
- req_addr  in  ADDR_W  line address from the instruction cache.
- l2_req  out  1  request to the next level; registered.
- l2_addr  out  ADDR_W  line address of the current request; registered.
- l2_ack  in  1  next level accepted l2_addr; sampled only while l2_req = 1.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- count  out  $clog2(DEPTH)+1  occupied entries.
- issued  out  32  requests acknowledged.
- merged  out  32  requests absorbed as duplicates.
- dropped  out  32  requests lost to overflow.

## Operation
- Storage is a circular buffer: entry array, valid bits, head and tail pointers, and count. Pointers wrap modulo DEPTH.
- The head entry is the in-flight request. It stays queued until acknowledged.
- Push, evaluated when req_valid = 1, in priority order:
  - Merge: req_addr equals any valid entry as it stands before the edge, including a head being popped this edge. The request is not enqueued; merged++.
  - Accept: count < DEPTH, or a pop occurs this same edge. Write at tail, tail++, valid set.
  - Drop: otherwise. dropped++ and the queue is unchanged.
- FSM states:
  - IDLE: if count > 0 at the edge, load l2_addr from the head, set l2_req = 1, go to ISSUE. Otherwise stay.
  - ISSUE: hold l2_req and l2_addr stable. When l2_ack = 1, pop the head (head++, count--, valid cleared), issued++, l2_req = 0, go to IDLE.
- l2_ack while in IDLE is ignored.
- A simultaneous push and pop leaves count unchanged.
- flush = 1 at an edge does all of the following:
  - Clears queue, pointers and counters, and returns the FSM to IDLE with l2_req = 0.
  - Abandons any in-flight request; its l2_ack is ignored.
  - Ignores req_valid that cycle.
  - Flush has priority over everything else.
- Counters are 32-bit and wrap from 0xFFFFFFFF to 0. No saturation.
- count, full and empty are derived from registered state.

## Timing
- Reset values: l2_req = 0, l2_addr = 0, count = 0, empty = 1, full = 0, issued = merged = dropped = 0, FSM in IDLE, pointers 0, all valid bits 0.
- A push at edge k is visible in count after edge k.
- If the FSM was idle and the queue empty, l2_req rises after edge k+1. Enqueue-to-request latency is 2 edges.
- An ack at edge m drops l2_req after edge m. The next request rises after edge m+1 at the earliest, so peak throughput is one request per 2 cycles.
- l2_addr changes only on the IDLE→ISSUE transition.
- Reset asserted mid-request drops l2_req asynchronously. No pop is performed and issued is unchanged.

## Test plan
- Single miss: reset, push 0x1234567 at edge 1 → count = 1 after edge 1; l2_req = 1 with l2_addr = 0x1234567 after edge 2; ack at edge 4 → l2_req = 0, count = 0, issued = 1.
- Merge: push 0x0000AAA, then push 0x0000AAA again before ack → count stays 1, merged = 1, exactly one l2 request issued.
- Overflow: hold l2_ack = 0; push 0x1, 0x2, 0x3, 0x4, 0x5 → full = 1 after the 4th push, dropped = 1; acks then return addresses 0x1, 0x2, 0x3, 0x4 in order.
- Full with pop: queue full, l2_ack = 1, push 0x9 in the same edge → 0x9 accepted, count stays 4, dropped = 0.
- Wrap-around: 10 sequential distinct pushes, each acked before the next → l2_addr order matches push order, issued = 10, pointers wrap without loss.
- Flush/reset mid-operation: 3 entries queued, l2_req = 1; assert flush → l2_req = 0, count = 0, all counters 0, a following l2_ack is ignored; repeat with asynchronous reset asserted between edges → outputs clear before the next edge.
